// File: rtl/scratch_pad_pkg.sv
// Shared encodings for the scratch pad stream DMA.
// State and direction constants plus the counter-width helper.
package scratch_pad_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  function automatic int sp_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/sp_stream_resp_fifo.sv
// First-word-fall-through response FIFO for the stream DMA.
// Exposes its fill count so the issuer can budget read credits.
module sp_stream_resp_fifo
  import scratch_pad_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int RESP_DEPTH = 32,
  localparam int PW        = sp_log2(RESP_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic [PW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [RESP_DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == (PW+1)'(RESP_DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && valid_o;
  // a full FIFO still accepts when its head leaves in the same cycle
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)
        cnt_q <= cnt_q + (PW+1)'(1);
      else if (!do_push && do_pop)
        cnt_q <= cnt_q - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/scratch_pad_stream_dma.sv
// Command-driven stream engine on one scratch pad port.
// Define SP_STREAM_DMA_STATS_EN to add full/busy cycle counters.
module scratch_pad_stream_dma
  import scratch_pad_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 16,
  parameter int RESP_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  done,
  output logic                  sp_rd_en,
  output logic                  sp_wr_en,
  output logic [ADDR_WIDTH-1:0] sp_addr,
  output logic [WIDTH-1:0]      sp_d,
  input  logic                  sp_full,
  output logic                  sp_stall,
  input  logic                  sp_valid,
  input  logic [WIDTH-1:0]      sp_q
`ifdef SP_STREAM_DMA_STATS_EN
  ,
  output logic [31:0]           stat_full_cycles,
  output logic [31:0]           stat_busy_cycles
`endif
);

  localparam int CW = sp_log2(RESP_DEPTH) + 1;
  localparam logic [LEN_WIDTH-1:0] ONE_L = LEN_WIDTH'(1);

  state_e                state_q;
  logic                  dir_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issue_cnt_q;
  logic [LEN_WIDTH-1:0]  deliv_cnt_q;
  logic [CW-1:0]         outst_q;
  logic                  sp_rd_en_q;
  logic                  sp_wr_en_q;
  logic [ADDR_WIDTH-1:0] sp_addr_q;
  logic [WIDTH-1:0]      sp_d_q;
  logic                  done_q;

  logic          accept;
  logic          credit_ok;
  logic          rd_go;
  logic          wr_go;
  logic          issue;
  logic          pop;
  logic          ret;
  logic          fifo_full;
  logic [CW-1:0] fifo_cnt;

  assign accept    = cmd_valid && cmd_ready;
  assign cmd_ready = (state_q == IDLE);
  assign in_ready  = (state_q == ISSUE) && (dir_q == DIR_WRITE) &&
                     !sp_full && (issue_cnt_q != len_q);
  assign credit_ok = ({1'b0, outst_q} + {1'b0, fifo_cnt}) <
                     (CW+1)'(RESP_DEPTH);
  assign rd_go     = (state_q == ISSUE) && (dir_q == DIR_READ) &&
                     !sp_full && credit_ok && (issue_cnt_q != len_q);
  assign wr_go     = in_valid && in_ready;
  assign issue     = rd_go || wr_go;
  assign pop       = out_valid && out_ready;
  // stray responses with nothing outstanding are dropped, not queued
  assign ret       = sp_valid && (outst_q != '0);
  assign sp_stall  = fifo_full && (outst_q != '0);

  assign sp_rd_en = sp_rd_en_q;
  assign sp_wr_en = sp_wr_en_q;
  assign sp_addr  = sp_addr_q;
  assign sp_d     = sp_d_q;
  assign done     = done_q;

  sp_stream_resp_fifo #(
    .WIDTH      (WIDTH),
    .RESP_DEPTH (RESP_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ret),
    .data_i  (sp_q),
    .pop_i   (pop),
    .valid_o (out_valid),
    .data_o  (out_data),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dir_q       <= DIR_READ;
      addr_q      <= '0;
      stride_q    <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      deliv_cnt_q <= '0;
      outst_q     <= '0;
      sp_rd_en_q  <= 1'b0;
      sp_wr_en_q  <= 1'b0;
      sp_addr_q   <= '0;
      sp_d_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      sp_rd_en_q <= rd_go;
      sp_wr_en_q <= wr_go;
      done_q     <= 1'b0;
      if (issue) begin
        sp_addr_q   <= addr_q;
        addr_q      <= addr_q + stride_q;
        issue_cnt_q <= issue_cnt_q + ONE_L;
      end
      if (wr_go) sp_d_q <= in_data;
      if (pop) deliv_cnt_q <= deliv_cnt_q + ONE_L;
      if (rd_go && !ret)
        outst_q <= outst_q + CW'(1);
      else if (!rd_go && ret)
        outst_q <= outst_q - CW'(1);
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            dir_q       <= cmd_write;
            addr_q      <= cmd_base;
            stride_q    <= cmd_stride;
            len_q       <= cmd_len;
            issue_cnt_q <= '0;
            deliv_cnt_q <= '0;
            if (cmd_len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (dir_q == DIR_READ) begin
            if (rd_go && (issue_cnt_q + ONE_L == len_q))
              state_q <= DRAIN;
          end else if (issue_cnt_q == len_q) begin
            // last write enable is on the port this cycle
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DRAIN: begin
          if ((deliv_cnt_q == len_q) ||
              (pop && (deliv_cnt_q + ONE_L == len_q))) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end

`ifdef SP_STREAM_DMA_STATS_EN
  logic [31:0] full_cyc_q;
  logic [31:0] busy_cyc_q;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      full_cyc_q <= '0;
      busy_cyc_q <= '0;
    end else begin
      if ((state_q != IDLE) && (busy_cyc_q != '1))
        busy_cyc_q <= busy_cyc_q + 32'd1;
      if ((state_q == ISSUE) && sp_full && (full_cyc_q != '1))
        full_cyc_q <= full_cyc_q + 32'd1;
    end
  end

  assign stat_full_cycles = full_cyc_q;
  assign stat_busy_cycles = busy_cyc_q;
`endif

endmodule

// File: tb/tb_scratch_pad_stream_dma.sv
// Directed and randomized bench for scratch_pad_stream_dma.
// Scratch pad is an array plus fixed-latency in-order reply queue.
module tb_scratch_pad_stream_dma;

  localparam int RESP_DEPTH = 32;
  localparam int LAT        = 6;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_base;
  logic [11:0] cmd_stride;
  logic [15:0] cmd_len;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        done;
  logic        sp_rd_en;
  logic        sp_wr_en;
  logic [11:0] sp_addr;
  logic [63:0] sp_d;
  logic        sp_full;
  logic        sp_stall;
  logic        sp_valid;
  logic [63:0] sp_q;
`ifdef SP_STREAM_DMA_STATS_EN
  logic [31:0] stat_full_cycles;
  logic [31:0] stat_busy_cycles;
`endif

  scratch_pad_stream_dma dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_base   (cmd_base),
    .cmd_stride (cmd_stride),
    .cmd_len    (cmd_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .done       (done),
    .sp_rd_en   (sp_rd_en),
    .sp_wr_en   (sp_wr_en),
    .sp_addr    (sp_addr),
    .sp_d       (sp_d),
    .sp_full    (sp_full),
    .sp_stall   (sp_stall),
    .sp_valid   (sp_valid),
    .sp_q       (sp_q)
`ifdef SP_STREAM_DMA_STATS_EN
    ,
    .stat_full_cycles (stat_full_cycles),
    .stat_busy_cycles (stat_busy_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;
  time tn = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scratch pad reference
  typedef struct {
    time         due;
    logic [63:0] d;
  } resp_t;

  logic [63:0] mem [4096];
  resp_t       rq [$];
  logic [11:0] rd_log [$];
  logic [11:0] wr_alog [$];
  logic [63:0] wr_dlog [$];
  time         t_last_wr = 0;
  bit          rst_at_edge = 1'b1;
  bit          full_at_edge = 1'b0;

  always @(posedge clk) begin
    rst_at_edge  = rst;
    full_at_edge = sp_full;
  end

  always @(negedge clk) begin
    if (rst_at_edge) begin
      rq.delete();
      sp_valid = 1'b0;
    end else begin
      check("stall_never", {63'd0, sp_stall}, 64'd0);
      check("rd_wr_excl", {63'd0, sp_rd_en && sp_wr_en}, 64'd0);
      if (sp_rd_en || sp_wr_en)
        check("req_under_full", {63'd0, full_at_edge}, 64'd0);
      if (sp_rd_en) begin
        rq.push_back('{$time + LAT * 10, mem[sp_addr]});
        rd_log.push_back(sp_addr);
      end
      if (sp_wr_en) begin
        mem[sp_addr] = sp_d;
        wr_alog.push_back(sp_addr);
        wr_dlog.push_back(sp_d);
        t_last_wr = $time;
      end
      if (rq.size() > 0 && rq[0].due <= $time) begin
        sp_valid = 1'b1;
        sp_q     = rq[0].d;
        void'(rq.pop_front());
      end else begin
        sp_valid = 1'b0;
      end
    end
  end

  task automatic sync();
    @(negedge clk);
    tn = $time;
  endtask

  task automatic start_cmd(input logic wr, input logic [11:0] base,
                           input logic [11:0] stride,
                           input logic [15:0] len);
    sp_full    = 1'b0;
    cmd_valid  = 1'b1;
    cmd_write  = wr;
    cmd_base   = base;
    cmd_stride = stride;
    cmd_len    = len;
    #1;
    check("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    sync();
    cmd_valid = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] base, input logic [11:0] stride,
                         input int len, input int rdy_pct,
                         input int full_pct, input int hold,
                         input int abort_at);
    logic [63:0] expq [$];
    logic [11:0] a;
    int  k;
    int  rd0;
    bit  fin;
    time t_hs;
    for (int i = 0; i < len; i++) begin
      a = 12'(base + i * stride);
      expq.push_back(mem[a]);
    end
    rd_log.delete();
    start_cmd(1'b0, base, stride, 16'(len));
    k = 0;
    fin = 1'b0;
    t_hs = 0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      if (abort_at > 0 && k == abort_at) begin
        out_ready = 1'b0;
        rst = 1'b1;
        sync();
        rst = 1'b0;
        #1;
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        rd0 = rd_log.size();
        repeat (20) begin
          sync();
          #1;
          check("rst_no_done", {63'd0, done}, 64'd0);
        end
        check("rst_no_reads", 64'(rd_log.size()), 64'(rd0));
        return;
      end
      out_ready = (c >= hold) && ($urandom_range(99) < rdy_pct);
      sp_full   = ($urandom_range(99) < full_pct);
      #1;
      if (hold > 0 && c == hold)
        check("rd_credit_cap", 64'(rd_log.size()), 64'(RESP_DEPTH));
      if (done) begin
        check("rd_done_lag", 64'(tn - t_hs), 64'd10);
        check("rd_count", 64'(k), 64'(len));
        fin = 1'b1;
      end else if (out_valid && out_ready) begin
        if (k < len) check("rd_data", out_data, expq[k]);
        else check("rd_extra_word", 64'(k), 64'(len - 1));
        if (k == len - 1) t_hs = tn;
        k++;
      end
      sync();
    end
    out_ready = 1'b0;
    sp_full   = 1'b0;
    if (!fin) check("rd_timeout", {63'd0, fin}, 64'd1);
    check("rd_issued", 64'(rd_log.size()), 64'(len));
    for (int i = 0; i < len; i++)
      check("rd_addr", {52'd0, rd_log[i]}, {52'd0, 12'(base + i * stride)});
  endtask

  task automatic do_write(input logic [11:0] base, input logic [11:0] stride,
                          input int len, input int vld_pct,
                          input int full_pct);
    logic [63:0] wd [$];
    int k;
    int rd0;
    bit fin;
    for (int i = 0; i < len; i++) wd.push_back({$urandom, $urandom});
    wr_alog.delete();
    wr_dlog.delete();
    rd0 = rd_log.size();
    start_cmd(1'b1, base, stride, 16'(len));
    k = 0;
    fin = 1'b0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      sp_full  = ($urandom_range(99) < full_pct);
      in_valid = (k < len) && ($urandom_range(99) < vld_pct);
      if (k < len) in_data = wd[k];
      #1;
      if (done) begin
        check("wr_done_lag", 64'(tn - t_last_wr), 64'd10);
        check("wr_count", 64'(k), 64'(len));
        fin = 1'b1;
      end else if (in_valid && in_ready) begin
        k++;
      end
      sync();
    end
    in_valid = 1'b0;
    sp_full  = 1'b0;
    if (!fin) check("wr_timeout", {63'd0, fin}, 64'd1);
    check("wr_issued", 64'(wr_alog.size()), 64'(len));
    check("wr_no_reads", 64'(rd_log.size()), 64'(rd0));
    for (int i = 0; i < len; i++) begin
      check("wr_addr", {52'd0, wr_alog[i]}, {52'd0, 12'(base + i * stride)});
      check("wr_data", wr_dlog[i], wd[i]);
    end
  endtask

  int rdz;
  int wrz;

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_base   = '0;
    cmd_stride = '0;
    cmd_len    = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    sp_full    = 1'b0;
    sp_valid   = 1'b0;
    sp_q       = '0;
    for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom};
    repeat (3) sync();
    rst = 1'b0;
    #1;
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_sp_rd_en", {63'd0, sp_rd_en}, 64'd0);
    check("rst_sp_wr_en", {63'd0, sp_wr_en}, 64'd0);
    check("rst_sp_stall", {63'd0, sp_stall}, 64'd0);
    check("rst_sp_addr", {52'd0, sp_addr}, 64'd0);
    check("rst_sp_d", sp_d, 64'd0);
    sync();

    do_read(12'h010, 12'h001, 8, 100, 0, 0, 0);
    sync();
    do_write(12'hFFE, 12'h001, 4, 100, 0);
    sync();
    do_read(12'h100, 12'h001, 100, 100, 0, 200, 0);
    sync();
    do_read(12'h200, 12'h003, 50, 70, 50, 0, 0);
    sync();

    rdz = rd_log.size();
    wrz = wr_alog.size();
    start_cmd(1'b0, 12'h123, 12'h001, 16'd0);
    #1;
    check("len0_done", {63'd0, done}, 64'd1);
    check("len0_cmd_ready_low", {63'd0, cmd_ready}, 64'd0);
    sync();
    #1;
    check("len0_done_clear", {63'd0, done}, 64'd0);
    check("len0_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("len0_no_rd", 64'(rd_log.size()), 64'(rdz));
    check("len0_no_wr", 64'(wr_alog.size()), 64'(wrz));
    sync();

    do_read(12'h300, 12'h001, 40, 100, 0, 0, 10);
    sync();
    do_read(12'h340, 12'h002, 20, 100, 0, 0, 0);
    sync();

    do_write(12'h800, 12'h005, 30, 60, 30);
    sync();
    do_read(12'h800, 12'h005, 30, 50, 30, 0, 0);
    sync();
    repeat (4) begin
      do_read(12'($urandom), 12'($urandom_range(0, 15)),
              int'($urandom_range(1, 60)), int'($urandom_range(30, 100)),
              int'($urandom_range(0, 40)), 0, 0);
      sync();
      do_write(12'($urandom), 12'($urandom_range(0, 15)),
               int'($urandom_range(1, 40)), int'($urandom_range(30, 100)),
               int'($urandom_range(0, 40)));
      sync();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
